// File: rtl/tt_ctrl_drv_pkg.sv
// Shared types and helpers for the tile selection control driver.
`include "tt_defs.vh"

package tt_ctrl_drv_pkg;

  localparam int SEL_W = `TT_SEL_W;
  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_INC_HI,
    ST_INC_LO,
    ST_SETTLE,
    ST_ENABLE
  } state_t;

  function automatic logic [SEL_W-1:0] tt_addr(input logic [3:0] row,
                                               input logic       side,
                                               input logic [4:0] col);
    logic [SEL_W-1:0] a;
    a = '0;
    a[`TT_ROW_MSB:`TT_ROW_LSB] = row;
    a[`TT_SIDE_BIT]            = side;
    a[`TT_COL_MSB:`TT_COL_LSB] = col;
    return a;
  endfunction

endpackage

// File: rtl/tt_ctrl_drv_timer.sv
// Load/decrement down-counter; zero flag reflects the registered count.
import tt_ctrl_drv_pkg::*;

module tt_ctrl_drv_timer (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_defs.vh
// Selection address geometry shared by the tt_ctrl_drv block and its users.
// Address layout is {row, side, col}; only the field positions live here.
`ifndef TT_DEFS_VH
`define TT_DEFS_VH
`define TT_SEL_W    10
`define TT_ROW_MSB  9
`define TT_ROW_LSB  6
`define TT_SIDE_BIT 5
`define TT_COL_MSB  4
`define TT_COL_LSB  0
`endif

// File: rtl/tt_ctrl_drv.sv
// Drives the remote ripple-counter design selector: optional counter reset,
// N increment pulses, a settle wait, then the enable with a done pulse.
`include "tt_defs.vh"
import tt_ctrl_drv_pkg::*;

module tt_ctrl_drv #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned INC_HI_CYCLES = 2,
  parameter int unsigned INC_LO_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [`TT_SEL_W-1:0] req_addr,
  input  logic                 req_ena,
  input  logic                 req_force_rst,
  output logic                 ctrl_sel_rst_n,
  output logic                 ctrl_sel_inc,
  output logic                 ctrl_ena,
  output logic                 done,
  output logic [`TT_SEL_W-1:0] cur_addr,
  output logic                 cur_valid
);

  // Timer holds (length - 1) so a state lasts exactly its cycle count.
  localparam logic [TMR_W-1:0] RST_LD    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] HI_LD     = TMR_W'(INC_HI_CYCLES - 1);
  localparam logic [TMR_W-1:0] LO_LD     = TMR_W'(INC_LO_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic             rst_n_q, rst_n_d;
  logic             inc_q, inc_d;
  logic             ena_q, ena_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [SEL_W-1:0] cur_addr_q, cur_addr_d;
  logic             cur_valid_q, cur_valid_d;
  logic [SEL_W-1:0] pcnt_q, pcnt_d;
  logic             ena_lat_q, ena_lat_d;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic             full_mode;
  logic [SEL_W-1:0] diff;

  assign full_mode = req_force_rst | ~cur_valid_q | (req_addr < cur_addr_q);
  assign diff      = req_addr - cur_addr_q;

  tt_ctrl_drv_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    rst_n_d     = rst_n_q;
    inc_d       = inc_q;
    ena_d       = ena_q;
    done_d      = 1'b0;
    ready_d     = ready_q;
    cur_addr_d  = cur_addr_q;
    cur_valid_d = cur_valid_q;
    pcnt_d      = pcnt_q;
    ena_lat_d   = ena_lat_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        inc_d   = 1'b0;
        rst_n_d = cur_valid_q;
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d   = 1'b0;
          ena_d     = 1'b0;
          ena_lat_d = req_ena;
          tmr_load  = 1'b1;
          if (full_mode) begin
            state_d = ST_RESET;
            rst_n_d = 1'b0;
            pcnt_d  = req_addr;
            tmr_val = RST_LD;
          end else if (diff == '0) begin
            state_d = ST_SETTLE;
            pcnt_d  = '0;
            tmr_val = SETTLE_LD;
          end else begin
            state_d    = ST_INC_HI;
            inc_d      = 1'b1;
            cur_addr_d = cur_addr_q + 1'b1;
            pcnt_d     = diff - 1'b1;
            tmr_val    = HI_LD;
          end
        end
      end
      ST_RESET: begin
        if (tmr_zero) begin
          rst_n_d     = 1'b1;
          cur_valid_d = 1'b1;
          cur_addr_d  = '0;
          tmr_load    = 1'b1;
          if (pcnt_q == '0) begin
            state_d = ST_SETTLE;
            tmr_val = SETTLE_LD;
          end else begin
            state_d    = ST_INC_HI;
            inc_d      = 1'b1;
            cur_addr_d = SEL_W'(1);
            pcnt_d     = pcnt_q - 1'b1;
            tmr_val    = HI_LD;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_INC_HI: begin
        if (tmr_zero) begin
          state_d  = ST_INC_LO;
          inc_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LO_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_INC_LO: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (pcnt_q == '0) begin
            state_d = ST_SETTLE;
            tmr_val = SETTLE_LD;
          end else begin
            state_d    = ST_INC_HI;
            inc_d      = 1'b1;
            cur_addr_d = cur_addr_q + 1'b1;
            pcnt_d     = pcnt_q - 1'b1;
            tmr_val    = HI_LD;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_ENABLE;
          done_d  = 1'b1;
          ena_d   = ena_lat_q;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_ENABLE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        rst_n_d = cur_valid_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rst_n_q     <= 1'b0;
      inc_q       <= 1'b0;
      ena_q       <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      cur_addr_q  <= '0;
      cur_valid_q <= 1'b0;
      pcnt_q      <= '0;
      ena_lat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_n_q     <= rst_n_d;
      inc_q       <= inc_d;
      ena_q       <= ena_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      cur_addr_q  <= cur_addr_d;
      cur_valid_q <= cur_valid_d;
      pcnt_q      <= pcnt_d;
      ena_lat_q   <= ena_lat_d;
    end
  end

  assign req_ready      = ready_q;
  assign ctrl_sel_rst_n = rst_n_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ena_q;
  assign done           = done_q;
  assign cur_addr       = cur_addr_q;
  assign cur_valid      = cur_valid_q;

endmodule

// File: tb/tb_tt_ctrl_drv.sv
// Directed bench for tt_ctrl_drv with a ripple-counter model of the remote selector.
import tt_ctrl_drv_pkg::*;

module tb_tt_ctrl_drv;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_addr;
  logic       req_ena;
  logic       req_force_rst;
  logic       ctrl_sel_rst_n;
  logic       ctrl_sel_inc;
  logic       ctrl_ena;
  logic       done;
  logic [9:0] cur_addr;
  logic       cur_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0] model_cnt;

  tt_ctrl_drv dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_ena        (req_ena),
    .req_force_rst  (req_force_rst),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena),
    .done           (done),
    .cur_addr       (cur_addr),
    .cur_valid      (cur_valid)
  );

  always #5 clk = ~clk;

  // Remote 10-bit ripple counter: async clear, advances on inc rising edges.
  always @(posedge ctrl_sel_inc or negedge ctrl_sel_rst_n) begin
    if (!ctrl_sel_rst_n) model_cnt <= '0;
    else                 model_cnt <= model_cnt + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic [9:0] addr, input logic ena,
                         input logic frc, input int hold, input int exp_lat,
                         input int exp_pulses, input int exp_rstlow, input logic exp_ena);
    int   k, pulses, rstlow, ena_early;
    logic prev_inc;
    bit   got_done;
    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1);
    req_valid     = 1'b1;
    req_addr      = addr;
    req_ena       = ena;
    req_force_rst = frc;
    pulses = 0; rstlow = 0; ena_early = 0; k = 0; got_done = 0;
    prev_inc = ctrl_sel_inc;
    while (!got_done && k < 5000) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk({tag, ".busy_ready"}, req_ready, 0);
        chk({tag, ".ena_off"}, ctrl_ena, 0);
        req_addr      = ~addr;
        req_ena       = ~ena;
        req_force_rst = ~frc;
      end
      if (k >= hold) begin
        req_valid     = 1'b0;
        req_force_rst = 1'b0;
      end
      if (ctrl_sel_inc && !prev_inc) pulses++;
      prev_inc = ctrl_sel_inc;
      if (!ctrl_sel_rst_n) rstlow++;
      if (done) got_done = 1;
      else if (ctrl_ena) ena_early++;
    end
    chk({tag, ".done_seen"}, 32'(got_done), 1);
    chk({tag, ".latency"}, k, exp_lat);
    chk({tag, ".pulses"}, pulses, exp_pulses);
    chk({tag, ".rst_low"}, rstlow, exp_rstlow);
    chk({tag, ".ena_early"}, ena_early, 0);
    chk({tag, ".ena_done"}, ctrl_ena, exp_ena);
    chk({tag, ".cur_addr"}, cur_addr, addr);
    chk({tag, ".cur_valid"}, cur_valid, 1);
    chk({tag, ".model"}, model_cnt, cur_addr);
    @(negedge clk);
    chk({tag, ".done_1cyc"}, done, 0);
    chk({tag, ".idle_ready"}, req_ready, 1);
    chk({tag, ".ena_hold"}, ctrl_ena, exp_ena);
    chk({tag, ".idle_rst_n"}, ctrl_sel_rst_n, 1);
  endtask

  initial begin
    int k;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_ena = 1'b0; req_force_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.rst_n", ctrl_sel_rst_n, 0);
    chk("rst.inc", ctrl_sel_inc, 0);
    chk("rst.ena", ctrl_ena, 0);
    chk("rst.done", done, 0);
    chk("rst.ready", req_ready, 0);
    chk("rst.cur_valid", cur_valid, 0);
    chk("rst.cur_addr", cur_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.ready", req_ready, 1);
    chk("post_rst.rst_n", ctrl_sel_rst_n, 0);

    run_req("s1", 10'd3, 1'b1, 1'b0, 1, 25, 3, 4, 1'b1);
    run_req("s2", 10'd5, 1'b1, 1'b0, 6, 17, 2, 0, 1'b1);
    run_req("s3_full", 10'd2, 1'b1, 1'b0, 1, 21, 2, 4, 1'b1);
    run_req("s3_zero", 10'd2, 1'b1, 1'b0, 1, 9, 0, 0, 1'b1);
    run_req("s3_force", 10'd2, 1'b0, 1'b1, 1, 21, 2, 4, 1'b0);
    run_req("s4", tt_addr(4'd15, 1'b1, 5'd31), 1'b0, 1'b1, 1, 4105, 1023, 4, 1'b0);
    run_req("s4_same", 10'd1023, 1'b1, 1'b0, 1, 9, 0, 0, 1'b1);

    rst = 1'b1;
    @(negedge clk);
    chk("idle_rst.ena", ctrl_ena, 0);
    chk("idle_rst.cur_valid", cur_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    req_valid = 1'b1; req_addr = 10'd5; req_ena = 1'b1; req_force_rst = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!ctrl_sel_inc && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("s5.inc_seen", ctrl_sel_inc, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("s5.inc", ctrl_sel_inc, 0);
    chk("s5.rst_n", ctrl_sel_rst_n, 0);
    chk("s5.ena", ctrl_ena, 0);
    chk("s5.cur_valid", cur_valid, 0);
    chk("s5.cur_addr", cur_addr, 0);
    chk("s5.ready", req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("s5.post_ready", req_ready, 1);
    chk("s5.post_rst_n", ctrl_sel_rst_n, 0);
    run_req("s5_next", 10'd0, 1'b1, 1'b0, 1, 13, 0, 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
